// File: rtl/riscv_icache_2way.sv
// riscv_icache_2way: two-way set-associative instruction cache for the fetch stage.
// Serves one 32-bit instruction per cycle on hit, including fetches that straddle
// two lines. Lines are refilled one at a time through a ready handshake. Each set
// has an LRU bit that picks the victim. A fence.i flush walks every set.
// Optional feature: define RISCV_ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module riscv_icache_2way #(
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 128,
  parameter int ADDR       = 27,
  localparam int DATA_WIDTH = 8 * LINE_BYTES,
  localparam int OFF        = $clog2(LINE_BYTES),
  localparam int INDEX      = $clog2(SETS),
  localparam int TAG        = ADDR - INDEX - OFF,
  localparam int S_ADDR     = ADDR - OFF
) (
  input  logic                  i_riscv_icache_clk,
  input  logic                  i_riscv_icache_rst,
  input  logic [63:0]           i_riscv_icache_phys_addr,
  input  logic                  i_riscv_icache_req,
  input  logic                  i_riscv_icache_flush,
  input  logic                  i_riscv_icache_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_riscv_icache_mem_data_out,
`ifdef RISCV_ICACHE_PERF_CNT_EN
  output logic [31:0]           o_riscv_icache_hit_cnt,
  output logic [31:0]           o_riscv_icache_miss_cnt,
`endif
  output logic [S_ADDR-1:0]     o_riscv_icache_mem_addr,
  output logic                  o_riscv_icache_fsm_mem_rden,
  output logic [31:0]           o_riscv_icache_cpu_instr_out,
  output logic                  o_riscv_icache_cpu_stall
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // Storage: tags and data are plain write-enabled arrays; valid/LRU need reset.
  logic [TAG-1:0]        tag_way0_mem  [SETS];
  logic [TAG-1:0]        tag_way1_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_way0_mem [SETS];
  logic [DATA_WIDTH-1:0] data_way1_mem [SETS];

  logic [SETS-1:0]   valid0_q, valid0_d;
  logic [SETS-1:0]   valid1_q, valid1_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [1:0]        state_q, state_d;
  logic              rden_q, rden_d;
  logic [S_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic              need_l1_q, need_l1_d;
  logic              flush_pend_q, flush_pend_d;
  logic [INDEX-1:0]  flush_cnt_q, flush_cnt_d;

  // Lookup-side address decomposition
  logic [ADDR-1:0]   fetch_addr_s;
  logic [OFF-1:0]    off_s;
  logic [S_ADDR-1:0] line0_addr_s;
  logic [S_ADDR-1:0] line1_addr_s;
  logic [INDEX-1:0]  idx0_s;
  logic [INDEX-1:0]  idx1_s;
  logic [TAG-1:0]    tag0_s;
  logic [TAG-1:0]    tag1_s;
  logic              straddle_s;

  assign fetch_addr_s = i_riscv_icache_phys_addr[ADDR-1:0];
  assign off_s        = fetch_addr_s[OFF-1:0];
  assign line0_addr_s = fetch_addr_s[ADDR-1:OFF];
  // The next line wraps through the index into the tag, and modulo 2^S_ADDR.
  assign line1_addr_s = line0_addr_s + S_ADDR'(1);
  assign idx0_s       = line0_addr_s[INDEX-1:0];
  assign idx1_s       = line1_addr_s[INDEX-1:0];
  assign tag0_s       = line0_addr_s[S_ADDR-1:INDEX];
  assign tag1_s       = line1_addr_s[S_ADDR-1:INDEX];
  assign straddle_s   = (off_s > OFF'(LINE_BYTES - 4));

  // Hit detection for both candidate lines
  logic hit0_w0_s, hit0_w1_s, hit1_w0_s, hit1_w1_s;
  logic hit0_s, hit1_s, hit_needed_s, hit_taken_s;
  logic hit0_way_s, hit1_way_s;

  assign hit0_w0_s    = valid0_q[idx0_s] & (tag_way0_mem[idx0_s] == tag0_s);
  assign hit0_w1_s    = valid1_q[idx0_s] & (tag_way1_mem[idx0_s] == tag0_s);
  assign hit1_w0_s    = valid0_q[idx1_s] & (tag_way0_mem[idx1_s] == tag1_s);
  assign hit1_w1_s    = valid1_q[idx1_s] & (tag_way1_mem[idx1_s] == tag1_s);
  assign hit0_s       = hit0_w0_s | hit0_w1_s;
  assign hit1_s       = hit1_w0_s | hit1_w1_s;
  assign hit0_way_s   = hit0_w0_s ? 1'b0 : 1'b1;
  assign hit1_way_s   = hit1_w0_s ? 1'b0 : 1'b1;
  assign hit_needed_s = hit0_s & (~straddle_s | hit1_s);
  assign hit_taken_s  = (state_q == ST_IDLE) & i_riscv_icache_req & hit_needed_s;

  // Instruction extraction: bytes off..off+3 of {line1, line0}
  logic [DATA_WIDTH-1:0]   line0_data_s;
  logic [DATA_WIDTH-1:0]   line1_data_s;
  logic [2*DATA_WIDTH-1:0] pair_s;
  logic [2*DATA_WIDTH-1:0] shifted_s;

  assign line0_data_s = hit0_w0_s ? data_way0_mem[idx0_s] : data_way1_mem[idx0_s];
  assign line1_data_s = hit1_w0_s ? data_way0_mem[idx1_s] : data_way1_mem[idx1_s];
  assign pair_s       = {line1_data_s, line0_data_s};
  assign shifted_s    = pair_s >> {off_s, 3'b000};

  // Refill target: the line currently being requested from memory
  logic [INDEX-1:0] ref_idx_s;
  logic [TAG-1:0]   ref_tag_s;
  logic             victim_s;
  logic             refill_we_s;
  logic             refill_start_s;

  assign ref_idx_s = mem_addr_q[INDEX-1:0];
  assign ref_tag_s = mem_addr_q[S_ADDR-1:INDEX];

  // Victim choice: first invalid way (way 0 first), otherwise the LRU way
  always_comb begin
    victim_s = 1'b0;
    if (!valid0_q[ref_idx_s]) begin
      victim_s = 1'b0;
    end else if (!valid1_q[ref_idx_s]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_q[ref_idx_s];
    end
  end

  // Fetch-side stall and instruction output
  always_comb begin
    o_riscv_icache_cpu_stall     = 1'b1;
    o_riscv_icache_cpu_instr_out = 32'h0000_0013;
    if (state_q == ST_IDLE) begin
      o_riscv_icache_cpu_stall = i_riscv_icache_req & ~hit_needed_s;
    end else begin
      o_riscv_icache_cpu_stall = 1'b1;
    end
    if (o_riscv_icache_cpu_stall) begin
      o_riscv_icache_cpu_instr_out = 32'h0000_0013;
    end else begin
      o_riscv_icache_cpu_instr_out = shifted_s[31:0];
    end
  end

  // Controller next-state: lookup, refill sequencing, flush walk, LRU/valid updates
  always_comb begin
    state_d        = state_q;
    rden_d         = rden_q;
    mem_addr_d     = mem_addr_q;
    need_l1_d      = need_l1_q;
    flush_pend_d   = flush_pend_q;
    flush_cnt_d    = flush_cnt_q;
    valid0_d       = valid0_q;
    valid1_d       = valid1_q;
    lru_d          = lru_q;
    refill_we_s    = 1'b0;
    refill_start_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A served hit marks the other way as the next eviction candidate.
        if (hit_taken_s) begin
          lru_d[idx0_s] = ~hit0_way_s;
          if (straddle_s) begin
            lru_d[idx1_s] = ~hit1_way_s;
          end else begin
            lru_d[idx1_s] = lru_d[idx1_s];
          end
        end else begin
          lru_d = lru_q;
        end
        // Flush wins over a miss; the miss is found again after the walk.
        if (i_riscv_icache_flush) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = {INDEX{1'b0}};
        end else if (i_riscv_icache_req && !hit_needed_s) begin
          state_d        = ST_REFILL;
          rden_d         = 1'b1;
          refill_start_s = 1'b1;
          if (!hit0_s) begin
            mem_addr_d = line0_addr_s;
            need_l1_d  = straddle_s & ~hit1_s;
          end else begin
            mem_addr_d = line1_addr_s;
            need_l1_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REFILL: begin
        if (i_riscv_icache_flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (i_riscv_icache_mem_ready) begin
          refill_we_s = 1'b1;
          if (victim_s) begin
            valid1_d[ref_idx_s] = 1'b1;
          end else begin
            valid0_d[ref_idx_s] = 1'b1;
          end
          lru_d[ref_idx_s] = ~victim_s;
          if (need_l1_q) begin
            // Second half of a straddling fetch: request the following line.
            mem_addr_d     = mem_addr_q + S_ADDR'(1);
            need_l1_d      = 1'b0;
            refill_start_s = 1'b1;
          end else begin
            rden_d = 1'b0;
            if (flush_pend_q || i_riscv_icache_flush) begin
              state_d      = ST_FLUSH;
              flush_cnt_d  = {INDEX{1'b0}};
              flush_pend_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_REFILL;
        end
      end

      ST_FLUSH: begin
        valid0_d[flush_cnt_q] = 1'b0;
        valid1_d[flush_cnt_q] = 1'b0;
        if (flush_cnt_q == INDEX'(SETS - 1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = {INDEX{1'b0}};
        end else begin
          flush_cnt_d = flush_cnt_q + INDEX'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        rden_d  = 1'b0;
      end
    endcase
  end

  // Controller state registers with synchronous reset
  always_ff @(posedge i_riscv_icache_clk) begin
    if (i_riscv_icache_rst) begin
      state_q      <= ST_IDLE;
      rden_q       <= 1'b0;
      mem_addr_q   <= {S_ADDR{1'b0}};
      need_l1_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= {INDEX{1'b0}};
      valid0_q     <= {SETS{1'b0}};
      valid1_q     <= {SETS{1'b0}};
      lru_q        <= {SETS{1'b0}};
    end else begin
      state_q      <= state_d;
      rden_q       <= rden_d;
      mem_addr_q   <= mem_addr_d;
      need_l1_q    <= need_l1_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      lru_q        <= lru_d;
    end
  end

  // Refill write port into the victim way's tag and data arrays
  always_ff @(posedge i_riscv_icache_clk) begin
    if (refill_we_s && !i_riscv_icache_rst) begin
      if (victim_s) begin
        tag_way1_mem[ref_idx_s]  <= ref_tag_s;
        data_way1_mem[ref_idx_s] <= i_riscv_icache_mem_data_out;
      end else begin
        tag_way0_mem[ref_idx_s]  <= ref_tag_s;
        data_way0_mem[ref_idx_s] <= i_riscv_icache_mem_data_out;
      end
    end
  end

  assign o_riscv_icache_mem_addr     = mem_addr_q;
  assign o_riscv_icache_fsm_mem_rden = rden_q;

`ifdef RISCV_ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit / miss counter increments
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_taken_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (refill_start_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge i_riscv_icache_clk) begin
    if (i_riscv_icache_rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_riscv_icache_hit_cnt  = hit_cnt_q;
  assign o_riscv_icache_miss_cnt = miss_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = refill_start_s;
`endif

  // Upper address bits and the tail of the shifted line pair are intentionally dropped.
  logic unused_s;
  assign unused_s = ^{i_riscv_icache_phys_addr[63:ADDR], shifted_s[2*DATA_WIDTH-1:32]};

endmodule

// File: tb/tb_riscv_icache_2way.sv
// Self-checking bench for riscv_icache_2way (default parameters).
// A line-level cache model predicts stall/rden/mem_addr/instr each cycle;
// directed fetches also carry hand-computed literal expectations.
module tb_riscv_icache_2way;

  localparam int NS = 128;

  logic         clk = 1'b0;
  logic         rst, req, flush, mem_ready;
  logic [63:0]  paddr;
  logic [127:0] mem_data;
  logic [22:0]  mem_addr;
  logic         rden, stall;
  logic [31:0]  instr;
`ifdef RISCV_ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  riscv_icache_2way dut (
    .i_riscv_icache_clk          (clk),
    .i_riscv_icache_rst          (rst),
    .i_riscv_icache_phys_addr    (paddr),
    .i_riscv_icache_req          (req),
    .i_riscv_icache_flush        (flush),
    .i_riscv_icache_mem_ready    (mem_ready),
    .i_riscv_icache_mem_data_out (mem_data),
`ifdef RISCV_ICACHE_PERF_CNT_EN
    .o_riscv_icache_hit_cnt      (hit_cnt),
    .o_riscv_icache_miss_cnt     (miss_cnt),
`endif
    .o_riscv_icache_mem_addr     (mem_addr),
    .o_riscv_icache_fsm_mem_rden (rden),
    .o_riscv_icache_cpu_instr_out(instr),
    .o_riscv_icache_cpu_stall    (stall)
  );

  int checks = 0;
  int errors = 0;

  // Model state: resident lines per set/way, LRU, outstanding refills, flush walk.
  bit          mv0 [NS];
  bit          mv1 [NS];
  logic [15:0] mt0 [NS];
  logic [15:0] mt1 [NS];
  bit          mlru[NS];
  logic [22:0] mq[$];
  int          flush_left = 0;
  bit          mpend = 1'b0;
  int          mhits = 0;
  int          mmiss = 0;
  bit          started = 1'b0;
  int          lat = 3;
  logic [26:0] cur_a = 27'd0;
  int          rden_cnt = 0;
  logic [22:0] alog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the byte address.
  function automatic logic [7:0] mb(input logic [26:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [26:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mb(a + 27'(i));
    return w;
  endfunction

  function automatic logic [127:0] line_data(input logic [22:0] l);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = mb({l, 4'b0000} + 27'(i));
    return d;
  endfunction

  function automatic bit present(input logic [22:0] line, output bit way);
    int s;
    s = int'(line[6:0]);
    way = 1'b0;
    if (mv0[s] && mt0[s] == line[22:7]) return 1'b1;
    if (mv1[s] && mt1[s] == line[22:7]) begin
      way = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_hit(input logic [26:0] a);
    bit w, h0, h1, st;
    h0 = present(a[26:4], w);
    h1 = present(a[26:4] + 23'd1, w);
    st = (a[3:0] > 4'd12);
    return h0 && (!st || h1);
  endfunction

  task automatic install(input logic [22:0] line);
    int s;
    bit way;
    s = int'(line[6:0]);
    way = !mv0[s] ? 1'b0 : (!mv1[s] ? 1'b1 : mlru[s]);
    if (way) begin mv1[s] = 1'b1; mt1[s] = line[22:7]; end
    else     begin mv0[s] = 1'b1; mt0[s] = line[22:7]; end
    mlru[s] = ~way;
  endtask

  task automatic start_flush();
    flush_left = NS;
    mpend = 1'b0;
    for (int i = 0; i < NS; i++) begin mv0[i] = 1'b0; mv1[i] = 1'b0; end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit h0, h1, w0, w1, st;
    logic [22:0] l0;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin mv0[i] = 1'b0; mv1[i] = 1'b0; mlru[i] = 1'b0; end
      mq.delete();
      flush_left = 0; mpend = 1'b0; mhits = 0; mmiss = 0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (mq.size() > 0) begin
      if (flush) mpend = 1'b1;
      if (mem_ready) begin
        install(mq[0]);
        void'(mq.pop_front());
        if (mq.size() > 0) mmiss++;
        else if (mpend) start_flush();
      end
    end else begin
      l0 = cur_a[26:4];
      h0 = present(l0, w0);
      h1 = present(l0 + 23'd1, w1);
      st = (cur_a[3:0] > 4'd12);
      if (req && h0 && (!st || h1)) begin
        mhits++;
        mlru[int'(l0[6:0])] = ~w0;
        if (st) mlru[int'(l0[6:0] + 7'd1)] = ~w1;
      end
      if (flush) start_flush();
      else if (req && !(h0 && (!st || h1))) begin
        if (!h0) mq.push_back(l0);
        if (st && !h1) mq.push_back(l0 + 23'd1);
        mmiss++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every meaningful output against the model.
  initial begin
    bit exp_stall, exp_rden, prev_rden;
    logic [22:0] last_addr;
    prev_rden = 1'b0;
    last_addr = 23'd0;
    forever begin
      @(negedge clk);
      if (started) begin
        if (mq.size() > 0) begin
          exp_stall = 1'b1; exp_rden = 1'b1;
        end else if (flush_left > 0) begin
          exp_stall = 1'b1; exp_rden = 1'b0;
        end else begin
          exp_stall = req && !model_hit(cur_a); exp_rden = 1'b0;
        end
        check("stall", stall, exp_stall);
        check("rden", rden, exp_rden);
        if (exp_rden) check("mem_addr", mem_addr, mq[0]);
        if (exp_stall) check("instr_nop", instr, 32'h0000_0013);
        else if (req) check("instr", instr, word_at(cur_a));
`ifdef RISCV_ICACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, mhits);
        check("miss_cnt", miss_cnt, mmiss);
`endif
        if (rden === 1'b1) begin
          rden_cnt++;
          if (!prev_rden || mem_addr != last_addr) alog.push_back(mem_addr);
          last_addr = mem_addr;
        end
        prev_rden = (rden === 1'b1);
      end
    end
  end

  // Instruction memory: answers each request after 'lat' cycles of rden.
  initial begin
    int run;
    run = 0;
    mem_ready = 1'b0;
    mem_data = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rden !== 1'b1) run = 0;
      else if (mem_ready) run = 1;
      else run++;
      mem_ready = (rden === 1'b1) && (run == lat);
      mem_data = line_data(mem_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [26:0] a);
    cur_a = a;
    paddr = {37'h0_0BEEF, a};
  endtask

  // Present a fetch and count stall cycles until it is served (bounded).
  task automatic fetch(input logic [26:0] a, input int limit, output int n, output logic [31:0] ins);
    set_addr(a);
    req = 1'b1;
    n = 0;
    ins = 32'd0;
    rden_cnt = 0;
    alog.delete();
    forever begin
      @(negedge clk);
      if (stall === 1'b0) begin
        ins = instr;
        break;
      end
      n++;
      if (n >= limit) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout addr=%0h stalled=%0d cycles", a, n);
        break;
      end
    end
    step();
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    logic [31:0] ins;
    rst = 1'b1; req = 1'b1; flush = 1'b0;
    set_addr(27'h100);

    // Reset state
    step();
    started = 1'b1;
    @(negedge clk);
    check("reset_stall", stall, 1'b1);
    check("reset_rden", rden, 1'b0);
    check("reset_mem_addr", mem_addr, 23'd0);
    step();
    rst = 1'b0; req = 1'b0;
    step();

    // Cold fetch at 0x100, memory latency 3
    fetch(27'h100, 50, n, ins);
    check("cold_stall_cycles", n, 4);
    check("cold_rden_cycles", rden_cnt, 3);
    check("cold_mem_addr", alog[0], 23'h10);
    check("cold_instr", ins, 32'hA7A6A5A4);

    // Set 5: two tags alternate, then a third evicts the LRU one
    fetch(27'h0050, 50, n, ins); check("lru_a_first", n, 4);
    fetch(27'h0850, 50, n, ins); check("lru_b_first", n, 4);
    fetch(27'h0050, 50, n, ins); check("lru_a_hit", n, 0);
    fetch(27'h0850, 50, n, ins); check("lru_b_hit", n, 0);
    fetch(27'h0050, 50, n, ins); check("lru_a_hit2", n, 0);
    fetch(27'h1050, 50, n, ins); check("lru_c_miss", n, 4);
    fetch(27'h0050, 50, n, ins); check("lru_a_kept", n, 0);
    fetch(27'h0850, 50, n, ins); check("lru_b_evicted", n, 4);

    // Straddling fetch with both lines cold
    fetch(27'h020E, 50, n, ins);
    check("strad_cycles", n, 7);
    check("strad_instr", ins, 32'hB6B7A8A9);
    check("strad_log_len", alog.size(), 2);
    check("strad_addr0", alog[0], 23'h20);
    check("strad_addr1", alog[1], 23'h21);

    // Straddle at index SETS-1: second line is index 0 with tag+1
    fetch(27'h07FE, 50, n, ins);
    check("wrap_instr", ins, 32'hACAD5D5C);
    check("wrap_addr0", alog[0], 23'h7F);
    check("wrap_addr1", alog[1], 23'h80);

    // Straddle at the top of the address space
    fetch(27'h7FF_FFFE, 50, n, ins);
    check("top_addr0", alog[0], 23'h7F_FFFF);
    check("top_addr1", alog[1], 23'h0);

    // Flush pulse during a refill
    set_addr(27'h0300);
    req = 1'b1;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch(27'h0300, 400, n, ins);
    check("flush_in_refill_cycles", n, 133);
    fetch(27'h0100, 50, n, ins);
    check("flush_cleared_0x100", n, 4);

    // Reset in the middle of a long refill
    lat = 50;
    set_addr(27'h0500);
    req = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_rden", rden, 1'b0);
`ifdef RISCV_ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    step();
    rst = 1'b0; req = 1'b0; lat = 3;
    fetch(27'h0100, 50, n, ins);
    check("rst_cleared_0x100", n, 4);

    // 10 hits and 2 line refills from a clean reset
    rst = 1'b1; req = 1'b0;
    step();
    step();
    rst = 1'b0;
    fetch(27'h0100, 50, n, ins);
    for (int i = 0; i < 4; i++) step();
    fetch(27'h0200, 50, n, ins);
    for (int i = 0; i < 4; i++) step();
    req = 1'b0;
    step();
    @(negedge clk);
`ifdef RISCV_ICACHE_PERF_CNT_EN
    check("perf_hit_cnt", hit_cnt, 32'd10);
    check("perf_miss_cnt", miss_cnt, 32'd2);
`endif
    check("perf_model_hits", mhits, 10);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
